// File: rtl/packet_framer.sv
// Packs one message of up to MAX_BYTES payload bytes into a 32-bit word stream:
// a length/stream word, a per-stream sequence number, then the left-aligned payload.
//
//  state  | meaning
//  S_IDLE | ready for a message; illegal lengths are dropped here with a lenErr pulse
//  S_HDR0 | presenting {msgLen+8, msgStream}
//  S_HDR1 | presenting the sequence number assigned at accept
//  S_DATA | presenting payload words 0..N-1, last flagged on N-1
module packet_framer #(
    parameter int STREAM_BITS = 5,
    parameter int MAX_BYTES   = 37
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [0:8*MAX_BYTES-1]   msgIn,
    input  logic [5:0]               msgLen,
    input  logic [15:0]              msgStream,
    input  logic                     msgSkip,
    input  logic                     msgIn_val,
    output logic                     msgIn_ready,
    output logic [31:0]              dataOut,
    output logic                     dataOut_val,
    input  logic                     dataOut_ready,
    output logic                     dataOut_last,
    output logic                     lenErr
);

    localparam int MAX_WORDS = (MAX_BYTES + 3) / 4;
    localparam int PAD_BITS  = 32 * MAX_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS);
    localparam int TAB_N     = 2 ** STREAM_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR0 = 2'd1,
        S_HDR1 = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic                     r_ready_en;
    logic                     r_len_err;
    logic [0:PAD_BITS-1]      r_msg;
    logic [5:0]               r_len;
    logic [15:0]              r_stream;
    logic [31:0]              r_seq;
    logic [IDX_W-1:0]         r_word;
    logic [31:0]              r_seq_tab [TAB_N];

    logic                     w_accept;
    logic                     w_len_ok;
    logic [STREAM_BITS-1:0]   w_tab_idx;
    logic [31:0]              w_seq_next;
    logic [0:PAD_BITS-1]      w_msg_masked;
    logic [6:0]               w_nwords;
    logic [IDX_W-1:0]         w_last_idx;
    logic                     w_is_last;

    assign w_accept   = msgIn_val && r_ready_en && (r_state == S_IDLE);
    assign w_len_ok   = (msgLen != 6'd0) && (int'(msgLen) <= MAX_BYTES);
    assign w_tab_idx  = msgStream[STREAM_BITS-1:0];
    assign w_seq_next = r_seq_tab[w_tab_idx] + (msgSkip ? 32'd2 : 32'd1);
    assign w_nwords   = ({1'b0, r_len} + 7'd3) >> 2;
    assign w_last_idx = IDX_W'(w_nwords - 7'd1);
    assign w_is_last  = (r_word == w_last_idx);
    assign lenErr     = r_len_err;

    // Bytes past msgLen are cleared once at accept, so every word later is a plain slice.
    always_comb begin
        w_msg_masked = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (b < int'(msgLen)) begin
                w_msg_masked[8*b +: 8] = msgIn[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        msgIn_ready  = 1'b0;
        dataOut      = 32'd0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                msgIn_ready = r_ready_en;
                if (w_accept && w_len_ok) begin
                    w_next = S_HDR0;
                end
            end
            S_HDR0: begin
                dataOut_val = 1'b1;
                dataOut     = {16'(r_len) + 16'd8, r_stream};
                if (dataOut_ready) begin
                    w_next = S_HDR1;
                end
            end
            S_HDR1: begin
                dataOut_val = 1'b1;
                dataOut     = r_seq;
                if (dataOut_ready) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                dataOut_val  = 1'b1;
                dataOut      = r_msg[32*r_word +: 32];
                dataOut_last = w_is_last;
                if (dataOut_ready && w_is_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ready_en <= 1'b0;
            r_len_err  <= 1'b0;
            r_msg      <= '0;
            r_len      <= 6'd0;
            r_stream   <= 16'd0;
            r_seq      <= 32'd0;
            r_word     <= '0;
            for (int i = 0; i < TAB_N; i++) begin
                r_seq_tab[i] <= 32'd0;
            end
        end else begin
            r_ready_en <= 1'b1;
            r_len_err  <= w_accept && !w_len_ok;
            // Table advances at accept so back-to-back messages on one stream never reuse a number.
            if (w_accept && w_len_ok) begin
                r_msg                <= w_msg_masked;
                r_len                <= msgLen;
                r_stream             <= msgStream;
                r_seq                <= w_seq_next;
                r_seq_tab[w_tab_idx] <= w_seq_next;
            end
            if (r_state == S_HDR1 && dataOut_ready) begin
                r_word <= '0;
            end else if (r_state == S_DATA && dataOut_ready) begin
                r_word <= r_word + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_framer.sv
// Scoreboard bench for packet_framer: a byte-level reference model queues expected words,
// a negedge monitor pops and compares every transferred word and lenErr pulse.
module tb_packet_framer;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic [0:295]  msgIn = '0;
    logic [5:0]    msgLen = 6'd0;
    logic [15:0]   msgStream = 16'd0;
    logic          msgSkip = 1'b0;
    logic          msgIn_val = 1'b0;
    logic          msgIn_ready;
    logic [31:0]   dataOut;
    logic          dataOut_val;
    logic          dataOut_ready = 1'b1;
    logic          dataOut_last;
    logic          lenErr;

    int            checks = 0;
    int            errors = 0;
    logic [32:0]   exp_q [$];
    int            exp_lenerr = 0;
    int            n_xfer = 0;
    bit            rnd_ready = 1'b0;
    logic [31:0]   model_seq [32];
    logic [7:0]    tx_bytes [37];

    packet_framer dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .msgIn         (msgIn),
        .msgLen        (msgLen),
        .msgStream     (msgStream),
        .msgSkip       (msgSkip),
        .msgIn_val     (msgIn_val),
        .msgIn_ready   (msgIn_ready),
        .dataOut       (dataOut),
        .dataOut_val   (dataOut_val),
        .dataOut_ready (dataOut_ready),
        .dataOut_last  (dataOut_last),
        .lenErr        (lenErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_seq[i] = 32'd0;
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 37; i++) tx_bytes[i] = 8'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int len, input logic [15:0] stream, input bit skip);
        int guard;
        int n;
        logic [31:0] w;
        logic [4:0]  idx;
        guard = 0;
        while (!msgIn_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 300) begin
                check("ready_timeout", 64'(msgIn_ready), 64'd1);
                return;
            end
        end
        for (int i = 0; i < 37; i++) msgIn[8*i +: 8] = tx_bytes[i];
        msgLen    = 6'(len);
        msgStream = stream;
        msgSkip   = skip;
        msgIn_val = 1'b1;
        if (len >= 1 && len <= 37) begin
            idx = stream[4:0];
            model_seq[idx] = model_seq[idx] + (skip ? 32'd2 : 32'd1);
            exp_q.push_back({1'b0, 16'(len + 8), stream});
            exp_q.push_back({1'b0, model_seq[idx]});
            n = (len + 3) / 4;
            for (int k = 0; k < n; k++) begin
                w = 32'd0;
                for (int j = 0; j < 4; j++) begin
                    w = (w << 8) | ((4*k + j < len) ? 32'(tx_bytes[4*k + j]) : 32'd0);
                end
                exp_q.push_back({(k == n - 1), w});
            end
        end else begin
            exp_lenerr++;
        end
        @(posedge clk); #1;
        msgIn_val = 1'b0;
        msgSkip   = 1'b0;
    endtask

    task automatic wait_xfer(input int target);
        int guard;
        guard = 0;
        while (n_xfer < target) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 500) begin
                check("xfer_timeout", 64'(n_xfer), 64'(target));
                return;
            end
        end
    endtask

    task automatic wait_empty();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 || dataOut_val) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin
                check("drain_timeout", 64'(exp_q.size()), 64'd0);
                return;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) dataOut_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic        prev_stall;
        logic [32:0] prev_word;
        logic [32:0] e;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_stable", 64'({dataOut_val, dataOut_last, dataOut}),
                          64'({1'b1, prev_word}));
                end
                if (dataOut_val) check("ready_while_busy", 64'(msgIn_ready), 64'd0);
                if (dataOut_val && dataOut_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected no word", {dataOut_last, dataOut});
                    end else begin
                        e = exp_q.pop_front();
                        check("word", 64'({dataOut_last, dataOut}), 64'(e));
                    end
                    n_xfer++;
                end
                if (lenErr) begin
                    checks++;
                    if (exp_lenerr > 0) begin
                        exp_lenerr--;
                    end else begin
                        errors++;
                        $display("FAIL lenErr_spurious: got 1 expected 0");
                    end
                end
                prev_stall = dataOut_val && !dataOut_ready;
                prev_word  = {dataOut_last, dataOut};
            end
        end
    end

    initial begin
        int base;
        int len;
        clear_model();
        #3;
        check("rst_ready", 64'(msgIn_ready), 64'd0);
        check("rst_val", 64'(dataOut_val), 64'd0);
        check("rst_data", 64'(dataOut), 64'd0);
        check("rst_last", 64'(dataOut_last), 64'd0);
        check("rst_lenErr", 64'(lenErr), 64'd0);
        #19 reset_b = 1'b1;
        #1 check("ready_before_first_edge", 64'(msgIn_ready), 64'd0);
        @(posedge clk); #1;
        check("ready_after_first_edge", 64'(msgIn_ready), 64'd1);

        // full 37-byte message
        for (int i = 0; i < 37; i++) tx_bytes[i] = 8'(i + 1);
        send(37, 16'h0003, 1'b0);
        wait_empty();

        // sequence numbering and aliasing
        rand_bytes(); send(8, 16'h0003, 1'b0);
        rand_bytes(); send(12, 16'h0023, 1'b0);
        rand_bytes(); send(3, 16'h0005, 1'b0);

        // short message with padding
        rand_bytes();
        tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB; tx_bytes[2] = 8'hCC;
        tx_bytes[3] = 8'hDD; tx_bytes[4] = 8'hEE;
        send(5, 16'h0007, 1'b0);
        wait_empty();

        // backpressure on word 2
        base = n_xfer;
        rand_bytes(); send(9, 16'h0011, 1'b0);
        wait_xfer(base + 2);
        dataOut_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        dataOut_ready = 1'b1;
        wait_empty();

        // skip and illegal lengths
        rand_bytes(); send(6, 16'h0003, 1'b1);
        rand_bytes(); send(0, 16'h0003, 1'b0);
        rand_bytes(); send(40, 16'h0003, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("lenErr_seen", 64'(exp_lenerr), 64'd0);
        rand_bytes(); send(4, 16'h0003, 1'b0);
        wait_empty();

        // reset during data word 1
        base = n_xfer;
        rand_bytes(); send(37, 16'h0003, 1'b0);
        wait_xfer(base + 3);
        #2 reset_b = 1'b0;
        #1;
        check("midrst_val", 64'(dataOut_val), 64'd0);
        check("midrst_ready", 64'(msgIn_ready), 64'd0);
        exp_q.delete();
        exp_lenerr = 0;
        clear_model();
        repeat (2) @(negedge clk);
        #2 reset_b = 1'b1;
        @(posedge clk); #1;
        rand_bytes(); send(6, 16'h0003, 1'b0);
        wait_empty();

        // randomized traffic with random backpressure
        rnd_ready = 1'b1;
        for (int m = 0; m < 150; m++) begin
            if ($urandom_range(0, 14) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(38, 63));
            else
                len = int'($urandom_range(1, 37));
            rand_bytes();
            send(len, 16'($urandom), ($urandom_range(0, 3) == 0));
        end
        wait_empty();
        rnd_ready = 1'b0;
        dataOut_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("final_lenErr_pending", 64'(exp_lenerr), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
